sysa_seq: RTL and testbench

//  Sequencer for the NxN weight-stationary systolic array (sysa) behind the TPU input FIFO.

---
 rtl/sysa_seq_if.sv | 42 ++++
 rtl/sysa_seq.sv | 191 +++++++++++++++++++
 tb/tb_sysa_seq.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sysa_seq_if.sv
// Bundle between the TPU front end, the sysa sequencer and the systolic array.
// The sequencer takes the slave view; the front end / array side takes the master view.
interface sysa_seq_if #(
    parameter int N  = 3,
    parameter int DW = 8,
    parameter int AW = 16
);
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic            start;
    logic [4:0]      num_rows;
    logic            w_valid;
    logic [N*DW-1:0] w_data;
    logic            w_ready;
    logic            x_valid;
    logic [N*DW-1:0] x_data;
    logic            x_ready;
    logic            sa_w_load;
    logic [IW-1:0]   sa_w_idx;
    logic [N*DW-1:0] sa_w_row;
    logic            sa_en;
    logic [N*DW-1:0] sa_in;
    logic [N*AW-1:0] sa_out;
    logic            r_valid;
    logic [N*AW-1:0] r_data;
    logic            r_ready;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, num_rows, w_valid, w_data, x_valid, x_data, sa_out, r_ready,
        input  w_ready, x_ready, sa_w_load, sa_w_idx, sa_w_row, sa_en, sa_in,
               r_valid, r_data, busy, done, err
    );

    modport slave (
        input  start, num_rows, w_valid, w_data, x_valid, x_data, sa_out, r_ready,
        output w_ready, x_ready, sa_w_load, sa_w_idx, sa_w_row, sa_en, sa_in,
               r_valid, r_data, busy, done, err
    );
endinterface

// File: rtl/sysa_seq.sv
// Sequencer for the NxN weight-stationary systolic array: weight load, skewed input
// streaming, output de-skew and a valid/ready result port that back-pressures the array.
module sysa_seq #(
    parameter int N        = 3,
    parameter int DW       = 8,
    parameter int AW       = 16,
    parameter int LAT      = 3,
    parameter int MAX_ROWS = 16
) (
    input  logic      clk,
    input  logic      rst,
    sysa_seq_if.slave bus
);
    localparam int         IW         = (N > 1) ? $clog2(N) : 1;
    localparam int         TRK        = N + LAT + 1;  // accept edge to result-load edge
    localparam logic [4:0] MAX_ROWS_W = 5'(MAX_ROWS);

    typedef enum logic [2:0] { S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN, S_DONE } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   w_cnt_q, w_cnt_d;
    logic [4:0]      rows_q, rows_d;
    logic [4:0]      acc_cnt_q, acc_cnt_d;
    logic [4:0]      out_cnt_q, out_cnt_d;
    logic            err_q, err_d;

    logic            w_ready, x_ready, sa_en, busy, done;
    logic            w_acc, x_acc, r_hs, stall, rows_ok, land;

    logic            sa_w_load_q;
    logic [IW-1:0]   sa_w_idx_q;
    logic [N*DW-1:0] sa_w_row_q;
    logic [TRK-1:0]  trk_q;
    logic [N*DW-1:0] sa_in;
    logic [N*AW-1:0] dsk;
    logic            r_valid_q;
    logic [N*AW-1:0] r_data_q;

    assign stall   = r_valid_q & ~bus.r_ready;
    assign w_acc   = bus.w_valid & w_ready;
    assign x_acc   = bus.x_valid & x_ready;
    assign r_hs    = r_valid_q & bus.r_ready;
    assign land    = sa_en & trk_q[TRK-1];
    assign rows_ok = (bus.num_rows != 5'd0) && (bus.num_rows <= MAX_ROWS_W);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // NOTE: each combinational block assigns a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (bus.start && rows_ok) state_d = S_LOAD_W;
            S_LOAD_W: if (w_acc && w_cnt_q == IW'(N-1)) state_d = S_STREAM;
            S_STREAM: if (x_acc && acc_cnt_q == rows_q - 5'd1) state_d = S_DRAIN;
            S_DRAIN:  if (out_cnt_d == 5'd0) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = 1'b0;
        x_ready = 1'b0;
        sa_en   = 1'b0;
        busy    = (state_q != S_IDLE);
        done    = (state_q == S_DONE);
        unique case (state_q)
            S_LOAD_W: w_ready = 1'b1;
            S_STREAM: begin
                x_ready = ~stall;
                sa_en   = ~stall;
            end
            S_DRAIN:  sa_en = ~stall;
            default:  ;
        endcase
    end

    // Job counters; a start outside IDLE is ignored entirely.
    always_comb begin
        w_cnt_d   = w_cnt_q;
        rows_d    = rows_q;
        acc_cnt_d = acc_cnt_q;
        out_cnt_d = out_cnt_q + {4'd0, x_acc} - {4'd0, r_hs};
        err_d     = (state_q == S_IDLE) && bus.start && !rows_ok;
        if (state_q == S_IDLE && bus.start && rows_ok) begin
            rows_d    = bus.num_rows;
            w_cnt_d   = '0;
            acc_cnt_d = 5'd0;
        end
        if (w_acc) w_cnt_d = w_cnt_q + 1'b1;
        if (x_acc) acc_cnt_d = acc_cnt_q + 5'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_cnt_q   <= '0;
            rows_q    <= 5'd0;
            acc_cnt_q <= 5'd0;
            out_cnt_q <= 5'd0;
            err_q     <= 1'b0;
        end else begin
            w_cnt_q   <= w_cnt_d;
            rows_q    <= rows_d;
            acc_cnt_q <= acc_cnt_d;
            out_cnt_q <= out_cnt_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa_w_load_q <= 1'b0;
            sa_w_idx_q  <= '0;
            sa_w_row_q  <= '0;
        end else begin
            sa_w_load_q <= w_acc;
            if (w_acc) begin
                sa_w_idx_q <= w_cnt_q;
                sa_w_row_q <= bus.w_data;
            end
        end
    end

    // Input skew: column j passes through j+1 stages, so it trails column 0 by j cycles.
    for (genvar j = 0; j < N; j++) begin : g_skew
        logic [DW-1:0] line_q [j+1];
        // NOTE: these register arrays are flops, not RAM, and are cleared on reset like any state.
        always_ff @(posedge clk) begin
            if (rst) begin
                for (int k = 0; k <= j; k++) line_q[k] <= '0;
            end else if (sa_en) begin
                line_q[0] <= x_acc ? bus.x_data[j*DW +: DW] : '0;
                for (int k = 1; k <= j; k++) line_q[k] <= line_q[k-1];
            end
        end
        assign sa_in[j*DW +: DW] = line_q[j];
    end

    always_ff @(posedge clk) begin
        if (rst)        trk_q <= '0;
        else if (sa_en) trk_q <= {trk_q[TRK-2:0], x_acc};
    end

    // De-skew: column j waits N-1-j cycles so all columns of a row align.
    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N-1) begin : g_direct
            assign dsk[j*AW +: AW] = bus.sa_out[j*AW +: AW];
        end else begin : g_delay
            logic [AW-1:0] dly_q [N-1-j];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int k = 0; k < N-1-j; k++) dly_q[k] <= '0;
                end else if (sa_en) begin
                    dly_q[0] <= bus.sa_out[j*AW +: AW];
                    for (int k = 1; k < N-1-j; k++) dly_q[k] <= dly_q[k-1];
                end
            end
            assign dsk[j*AW +: AW] = dly_q[N-2-j];
        end
    end

    // A landing row can only coincide with an empty or draining result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid_q <= 1'b0;
            r_data_q  <= '0;
        end else if (land) begin
            r_valid_q <= 1'b1;
            r_data_q  <= dsk;
        end else if (r_hs) begin
            r_valid_q <= 1'b0;
        end
    end

    assign bus.w_ready   = w_ready;
    assign bus.x_ready   = x_ready;
    assign bus.sa_w_load = sa_w_load_q;
    assign bus.sa_w_idx  = sa_w_idx_q;
    assign bus.sa_w_row  = sa_w_row_q;
    assign bus.sa_en     = sa_en;
    assign bus.sa_in     = sa_in;
    assign bus.r_valid   = r_valid_q;
    assign bus.r_data    = r_data_q;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_sysa_seq.sv
// Directed bench for sysa_seq with a behavioural weight-stationary array model on sa_*.
module tb_sysa_seq;
    localparam int N   = 3;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int LAT = 3;
    localparam int HD  = LAT + N;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    sysa_seq_if #(.N(N), .DW(DW), .AW(AW)) bus ();

    sysa_seq #(.N(N), .DW(DW), .AW(AW), .LAT(LAT), .MAX_ROWS(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Array model: out col j = sum_i x_i * W[i][j], col j valid LAT advances after its input
    // column was sampled, so col j lags col 0 by j cycles.
    logic [DW-1:0]   wt   [N][N];
    logic [N*DW-1:0] hist [HD];
    logic            en_s  = 1'b0;
    logic            wl_s  = 1'b0;
    logic            rst_s = 1'b0;
    logic [1:0]      wi_s  = '0;
    logic [N*DW-1:0] in_s  = '0;
    logic [N*DW-1:0] wr_s  = '0;
    logic [N*AW-1:0] m_out;
    int              m_acc;

    always @(negedge clk) begin
        en_s  = bus.sa_en;
        in_s  = bus.sa_in;
        wl_s  = bus.sa_w_load;
        wi_s  = bus.sa_w_idx;
        wr_s  = bus.sa_w_row;
        rst_s = rst;
    end

    always @(posedge clk) begin
        if (rst_s) begin
            for (int k = 0; k < HD; k++) hist[k] = '0;
            bus.sa_out <= '0;
        end else begin
            if (wl_s) for (int j = 0; j < N; j++) wt[wi_s][j] = wr_s[j*DW +: DW];
            if (en_s) begin
                for (int k = HD-1; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = in_s;
                for (int j = 0; j < N; j++) begin
                    m_acc = 0;
                    for (int i = 0; i < N; i++)
                        m_acc += int'(hist[LAT+j-i][i*DW +: DW]) * int'(wt[i][j]);
                    m_out[j*AW +: AW] = m_acc[AW-1:0];
                end
                bus.sa_out <= m_out;
            end
        end
    end

    function automatic logic [N*DW-1:0] px(input int a, input int b, input int c);
        return {DW'(c), DW'(b), DW'(a)};
    endfunction

    function automatic logic [N*AW-1:0] pr(input int a, input int b, input int c);
        return {AW'(c), AW'(b), AW'(a)};
    endfunction

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [N*DW-1:0] r0, input logic [N*DW-1:0] r1,
                          input logic [N*DW-1:0] r2);
        bus.w_valid = 1'b1;
        bus.w_data  = r0; step();
        bus.w_data  = r1; step();
        bus.w_data  = r2; step();
        bus.w_valid = 1'b0;
    endtask

    // Four-row all-ones-weight job; toggle gaps x_valid, stall_len holds r_ready low at first r_valid.
    task automatic run_rows(input bit toggle, input int stall_len, input string tag);
        logic [N*DW-1:0] xs    [4];
        logic [N*AW-1:0] exp_r [4];
        int sent = 0, got = 0, extra = 0, stall_cnt = 0, cyc = 0;
        bit fin = 1'b0;
        xs[0] = px(1, 1, 1); exp_r[0] = pr(3, 3, 3);
        xs[1] = px(2, 0, 0); exp_r[1] = pr(2, 2, 2);
        xs[2] = px(0, 3, 0); exp_r[2] = pr(3, 3, 3);
        xs[3] = px(4, 4, 4); exp_r[3] = pr(12, 12, 12);
        bus.start = 1'b1; bus.num_rows = 5'd4; step(); bus.start = 1'b0;
        load_w(px(1, 1, 1), px(1, 1, 1), px(1, 1, 1));
        while (!fin && cyc < 100) begin
            bus.x_valid = (sent < 4) && (!toggle || (cyc % 2 == 0));
            bus.x_data  = (sent < 4) ? xs[sent] : '0;
            bus.r_ready = (stall_cnt >= stall_len);
            @(negedge clk);
            if (bus.r_valid && bus.r_ready) begin
                if (got < 4) check({tag, "_result"}, bus.r_data, exp_r[got]);
                else extra++;
                got++;
            end
            if (bus.r_valid && !bus.r_ready) begin
                check({tag, "_stall_data"}, bus.r_data, (got < 4) ? exp_r[got] : '0);
                check({tag, "_stall_x_ready"}, bus.x_ready, 1'b0);
                check({tag, "_stall_sa_en"}, bus.sa_en, 1'b0);
                stall_cnt++;
            end
            if (bus.x_valid && bus.x_ready) sent++;
            if (bus.done) begin
                fin = 1'b1;
                check({tag, "_results_at_done"}, 64'(got), 64'd4);
                check({tag, "_busy_at_done"}, bus.busy, 1'b1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.x_valid = 1'b0;
        check({tag, "_done_seen"}, fin, 1'b1);
        check({tag, "_extra_results"}, 64'(extra), 64'd0);
        check({tag, "_busy_after"}, bus.busy, 1'b0);
        if (stall_len > 0) check({tag, "_stall_cycles"}, 64'(stall_cnt), 64'(stall_len));
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.num_rows = 5'd0;
        bus.w_valid = 1'b0; bus.w_data = '0;
        bus.x_valid = 1'b0; bus.x_data = '0;
        bus.r_ready = 1'b0;
        repeat (2) step();
        rst = 1'b0;
        step();

        check("reset_busy", bus.busy, 1'b0);
        check("reset_r_valid", bus.r_valid, 1'b0);
        check("reset_sa_en", bus.sa_en, 1'b0);
        check("reset_w_ready", bus.w_ready, 1'b0);
        check("reset_x_ready", bus.x_ready, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_err", bus.err, 1'b0);
        check("reset_sa_w_load", bus.sa_w_load, 1'b0);
        check("reset_r_data", bus.r_data, '0);
        check("reset_sa_in", bus.sa_in, '0);

        // T6: illegal row counts
        bus.start = 1'b1; bus.num_rows = 5'd0; step(); bus.start = 1'b0;
        check("t6_err_rows0", bus.err, 1'b1);
        check("t6_busy_rows0", bus.busy, 1'b0);
        step();
        check("t6_err_pulse_end", bus.err, 1'b0);
        bus.start = 1'b1; bus.num_rows = 5'd17; step(); bus.start = 1'b0;
        check("t6_err_rows17", bus.err, 1'b1);
        check("t6_busy_rows17", bus.busy, 1'b0);
        step();
        check("t6_err_pulse_end2", bus.err, 1'b0);

        // T2: identity weights, single row, plus a start while busy that must be ignored
        bus.r_ready = 1'b1;
        bus.start = 1'b1; bus.num_rows = 5'd1; step(); bus.start = 1'b0;
        check("t2_busy", bus.busy, 1'b1);
        check("t2_w_ready", bus.w_ready, 1'b1);
        bus.start = 1'b1; bus.num_rows = 5'd0;
        bus.w_valid = 1'b1; bus.w_data = px(1, 0, 0); step();
        bus.start = 1'b0;
        check("t6_start_busy_no_err", bus.err, 1'b0);
        check("t2_sa_w_load", bus.sa_w_load, 1'b1);
        check("t2_sa_w_idx", bus.sa_w_idx, 2'd0);
        check("t2_sa_w_row", bus.sa_w_row, px(1, 0, 0));
        bus.w_data = px(0, 1, 0); step();
        bus.w_data = px(0, 0, 1); step();
        bus.w_valid = 1'b0;
        check("t2_sa_w_idx_last", bus.sa_w_idx, 2'd2);
        check("t2_x_ready_stream", bus.x_ready, 1'b1);
        bus.x_valid = 1'b1; bus.x_data = px(1, 2, 3); step();
        bus.x_valid = 1'b0;
        check("t2_x_ready_drain", bus.x_ready, 1'b0);
        check("t2_skew0", bus.sa_in, px(1, 0, 0));
        step();
        check("t2_skew1", bus.sa_in, px(0, 2, 0));
        step();
        check("t2_skew2", bus.sa_in, px(0, 0, 3));
        for (int i = 2; i < 7; i++) begin
            check("t2_r_valid_early", bus.r_valid, 1'b0);
            step();
        end
        check("t2_r_valid", bus.r_valid, 1'b1);
        check("t2_r_data", bus.r_data, pr(1, 2, 3));
        check("t2_done_early", bus.done, 1'b0);
        step();
        check("t2_done", bus.done, 1'b1);
        check("t2_busy_done", bus.busy, 1'b1);
        check("t2_r_valid_clear", bus.r_valid, 1'b0);
        step();
        check("t2_done_pulse_end", bus.done, 1'b0);
        check("t2_idle", bus.busy, 1'b0);

        // T3 / T4 / T5
        run_rows(1'b0, 0, "t3");
        run_rows(1'b1, 0, "t4");
        run_rows(1'b0, 5, "t5");

        // T1: reset in the middle of streaming, then a clean job
        bus.r_ready = 1'b1;
        bus.start = 1'b1; bus.num_rows = 5'd4; step(); bus.start = 1'b0;
        load_w(px(1, 1, 1), px(1, 1, 1), px(1, 1, 1));
        bus.x_valid = 1'b1; bus.x_data = px(5, 6, 7); step(); step();
        bus.x_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
        check("t1_busy", bus.busy, 1'b0);
        check("t1_r_valid", bus.r_valid, 1'b0);
        check("t1_sa_en", bus.sa_en, 1'b0);
        check("t1_done", bus.done, 1'b0);
        step();
        check("t1_done_after", bus.done, 1'b0);
        run_rows(1'b0, 0, "t1_rerun");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
